store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//   Word store buffer between the single-cycle datapath and the data memory.
//   - Datapath stores are queued in a FIFO and drained in order, one per cycle, into the data memory write port.
//   - Loads check the buffer and forward the youngest matching pending store, so a load sees the same value it would see with direct memory writes.
//   - The buffer also carries each store's PC, so the write trace is produced with the original instruction address.
// PARAMETERS
//   DEPTH   4   number of entries; power of two, >= 2
//   PTR_W   2   log2(DEPTH); pointer width
// PORTS
//   clk        in   1    clock; all state updates on rising edge
//   reset      in   1    synchronous, active-high; clears buffer
//   st_valid   in   1    datapath presents a store this cycle
//   st_pc      in   32   PC of the store instruction
//   st_addr    in   32   byte address of the store; [1:0] ignored
//   st_wdata   in   32   store data word
//   st_ready   out  1    buffer can accept a store (= !full)
//   ld_addr    in   32   byte address of the current load; [1:0] ignored
//   fwd_hit    out  1    a pending entry matches ld_addr[31:2]
//   fwd_data   out  32   data of the youngest matching entry; 0 when !fwd_hit
//   mem_ready  in   1    data memory accepts the head write this cycle
//   mem_we     out  1    head entry valid, i.e. write request (= !empty)
//   mem_pc     out  32   PC of the head entry
//   mem_addr   out  32   {head addr[31:2], 2'b00}
//   mem_wdata  out  32   data of the head entry
//   empty      out  1    count == 0
// BEHAVIOUR
//   - State: entry arrays pc/addr[31:2]/data per slot, wr_ptr, rd_ptr, count (PTR_W+1 bits).
//   - Reset (synchronous): wr_ptr = rd_ptr = 0, count = 0; entry contents are don't-care.
//     Outputs after the reset edge: st_ready = 1, mem_we = 0, empty = 1, fwd_hit = 0, fwd_data = 0.
//     Reset overrides a push or pop in the same cycle; in-flight entries are discarded and never written.
//   - Push: on the edge with st_valid & st_ready.
//     Write slot[wr_ptr], then wr_ptr = wr_ptr + 1 (wraps modulo DEPTH).
//     st_valid while full: the store is dropped and no state changes. Avoiding this is the datapath's job; the bench flags it as an error.
//   - Pop: on the edge with mem_we & mem_ready; rd_ptr = rd_ptr + 1 (wraps modulo DEPTH).
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//     st_ready depends only on full; it does not rise combinationally on a same-cycle pop.
//   - count: +1 push only, -1 pop only, unchanged for both or neither. Never exceeds DEPTH and never underflows.
//   - Drain outputs are combinational from the registers at rd_ptr.
//     Zero-cycle request latency: a store pushed at edge N appears at the head after edge N if the buffer was empty.
//     With mem_ready held at 1, it is written to the data memory at edge N+1.
//   - Order: strictly FIFO; no merging or coalescing of stores to the same address.
//   - Forwarding: combinational. Compare ld_addr[31:2] against every valid entry, including the head being popped this cycle.
//     The youngest match wins: the highest age offset from rd_ptr, i.e. the entry nearest wr_ptr-1.
//     A store pushed in the current cycle is not visible to a load in the same cycle.
//   - Valid-entry test: (slot - rd_ptr) mod DEPTH < count. This handles wrap-around and the full case (count == DEPTH, wr_ptr == rd_ptr).
//   - No X on outputs after the first reset, even when empty; fwd_data is forced to 0 when there is no hit.
// TESTING
//   1. Reset, then st_valid=1, st_addr=0x10, st_wdata=0xAAAA0001, st_pc=0x3000, mem_ready=1
//      -> after edge: mem_we=1, mem_addr=0x10, mem_wdata=0xAAAA0001, mem_pc=0x3000; after next edge: empty=1.
//   2. mem_ready=0; push 4 stores to 0x0,0x4,0x8,0xC
//      -> st_ready=0 after the 4th. A 5th st_valid changes nothing. Raising mem_ready drains 0x0,0x4,0x8,0xC in order on 4 edges.
//   3. mem_ready=0; push 0x20<=1, then 0x24<=2, then 0x20<=3; ld_addr=0x22
//      -> fwd_hit=1, fwd_data=3. ld_addr=0x28 -> fwd_hit=0, fwd_data=0.
//   4. Full buffer, mem_ready=1 and st_valid=1 in the same cycle
//      -> pop only, count becomes 3. Next cycle push and pop together -> count stays 3. Pointers wrap past DEPTH-1 to 0 with correct drain order.
//   5. 3 entries pending, assert reset together with st_valid and mem_ready=1
//      -> after edge: empty=1, mem_we=0, st_ready=1. The pending entries are never presented.
//   6. Random push/pop vs reference queue model over 10k cycles
//      -> mem_* sequence and every fwd_data match the model exactly.

Source files
------------

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Word store buffer placed between a single-cycle datapath and the data
//   memory. Stores are queued in a small FIFO and drained in order, one per
//   cycle, into the memory write port. Loads search the buffer and receive the
//   youngest pending store to the same word, so a load observes the same value
//   it would see if stores were written to memory directly. Each entry also
//   carries the PC of its store so the write trace keeps the original
//   instruction address.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high clear of the buffer
//   st_valid   store presented by the datapath this cycle
//   st_pc      PC of the store instruction
//   st_addr    byte address of the store (bits [1:0] ignored)
//   st_wdata   store data word
//   st_ready   buffer can accept a store (not full)
//   ld_addr    byte address of the current load (bits [1:0] ignored)
//   fwd_hit    a pending entry matches ld_addr[31:2]
//   fwd_data   data of the youngest matching entry, 0 without a hit
//   mem_ready  memory accepts the head write this cycle
//   mem_we     head entry valid (buffer not empty)
//   mem_pc     PC of the head entry
//   mem_addr   word-aligned address of the head entry
//   mem_wdata  data of the head entry
//   empty      no pending entries
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_pc,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    output logic        st_ready,
    input  logic [31:0] ld_addr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        empty
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ZERO_C  = {(PTR_W + 1){1'b0}};

    logic [31:0]      pc_r   [DEPTH];
    logic [29:0]      addr_r [DEPTH];
    logic [31:0]      data_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_next_s;
    logic             empty_r;
    logic             full_r;
    logic             push_s;
    logic             pop_s;
    logic             fwd_hit_s;
    logic [31:0]      fwd_data_s;
    logic             unused_s;

    // Byte-offset bits carry no information for word stores and loads.
    assign unused_s = ^{st_addr[1:0], ld_addr[1:0]};

    // A store is only taken when the buffer is not full; the head is retired
    // whenever it is valid and memory accepts it.
    assign push_s = st_valid & ~full_r;
    assign pop_s  = ~empty_r & mem_ready;

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 1'b1;
            2'b01:   count_next_s = count_r - 1'b1;
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy and status-flag registers plus entry storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_C;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            // Entries are cleared so head outputs are never unknown.
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]   <= 32'h0000_0000;
                addr_r[i] <= 30'h0000_0000;
                data_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (push_s) begin
                pc_r[wr_ptr_r]   <= st_pc;
                addr_r[wr_ptr_r] <= st_addr[31:2];
                data_r[wr_ptr_r] <= st_wdata;
                wr_ptr_r         <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_next_s;
            // Flags are registered from the next count so they track count_r.
            empty_r <= (count_next_s == ZERO_C);
            full_r  <= (count_next_s == DEPTH_C);
        end
    end

    // Forwarding search ordered by age from the head; a later (younger) match
    // overwrites an earlier one, so the entry nearest wr_ptr-1 wins. The age
    // bound against count covers wrap-around and the full case.
    always_comb begin
        logic [PTR_W-1:0] slot_v;
        slot_v     = rd_ptr_r;
        fwd_hit_s  = 1'b0;
        fwd_data_s = 32'h0000_0000;
        for (int age = 0; age < DEPTH; age++) begin
            slot_v = rd_ptr_r + PTR_W'(age);
            if (((PTR_W + 1)'(age) < count_r) && (addr_r[slot_v] == ld_addr[31:2])) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = data_r[slot_v];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign st_ready  = ~full_r;
    assign mem_we    = ~empty_r;
    assign empty     = empty_r;
    assign mem_pc    = pc_r[rd_ptr_r];
    assign mem_addr  = {addr_r[rd_ptr_r], 2'b00};
    assign mem_wdata = data_r[rd_ptr_r];
    assign fwd_hit   = fwd_hit_s;
    assign fwd_data  = fwd_data_s;

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//   Self-checking bench for store_buffer. A queue-based reference model tracks
//   pending stores; a compare process checks every DUT output against it on
//   each falling clock edge. Directed sequences add hand-computed literal
//   expectations, followed by a long constrained-random phase.
// ---------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [29:0] wa;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_pc = 32'h0;
    logic [31:0] st_addr = 32'h0;
    logic [31:0] st_wdata = 32'h0;
    logic        st_ready;
    logic [31:0] ld_addr = 32'h0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        empty;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   armed = 1'b0;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_pc     (st_pc),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_ready  (st_ready),
        .ld_addr   (ld_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_pc    (mem_pc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending stores, updated on each edge.
    always @(posedge clk) begin : model_update
        automatic int n = q.size();
        if (reset) begin
            q.delete();
            armed = 1'b1;
        end else begin
            if (n > 0 && mem_ready) q.pop_front();
            if (st_valid && n < DEPTH) q.push_back('{pc: st_pc, wa: st_addr[31:2], data: st_wdata});
        end
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin : compare
        logic        exp_hit;
        logic [31:0] exp_data;
        if (armed) begin
            exp_hit  = 1'b0;
            exp_data = 32'h0;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].wa == ld_addr[31:2]) begin
                    exp_hit  = 1'b1;
                    exp_data = q[i].data;
                end
            end
            chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
            chk("mem_we",   32'(mem_we),   32'(q.size() > 0));
            chk("empty",    32'(empty),    32'(q.size() == 0));
            chk("fwd_hit",  32'(fwd_hit),  32'(exp_hit));
            chk("fwd_data", fwd_data,      exp_data);
            if (q.size() > 0) begin
                chk("mem_pc",    mem_pc,    q[0].pc);
                chk("mem_addr",  mem_addr,  {q[0].wa, 2'b00});
                chk("mem_wdata", mem_wdata, q[0].data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_pc    = p;
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_fwd_hit",  32'(fwd_hit),  32'd0);
        chk("rst_fwd_data", fwd_data,      32'h0);

        // 1: single store appears at the head right after its edge, drains next edge
        mem_ready = 1'b1;
        push_one(32'h10, 32'hAAAA_0001, 32'h3000);
        chk("t1_mem_we",    32'(mem_we), 32'd1);
        chk("t1_mem_addr",  mem_addr,    32'h10);
        chk("t1_mem_wdata", mem_wdata,   32'hAAAA_0001);
        chk("t1_mem_pc",    mem_pc,      32'h3000);
        step();
        chk("t1_empty",     32'(empty),  32'd1);

        // 2: fill, overflow attempt, in-order drain
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'(i * 4), 32'hB0 + 32'(i), 32'h4000 + 32'(i * 4));
        chk("t2_full", 32'(st_ready), 32'd0);
        push_one(32'h30, 32'hDEAD, 32'h4010);
        chk("t2_drop_ready", 32'(st_ready), 32'd0);
        chk("t2_drop_head",  mem_addr,      32'h0);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_addr", mem_addr,  32'(i * 4));
            chk("t2_drain_data", mem_wdata, 32'hB0 + 32'(i));
            step();
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: youngest-match forwarding
        mem_ready = 1'b0;
        push_one(32'h20, 32'd1, 32'h5000);
        push_one(32'h24, 32'd2, 32'h5004);
        push_one(32'h20, 32'd3, 32'h5008);
        ld_addr = 32'h22;
        #1;
        chk("t3_hit",  32'(fwd_hit), 32'd1);
        chk("t3_data", fwd_data,     32'd3);
        ld_addr = 32'h28;
        #1;
        chk("t3_miss_hit",  32'(fwd_hit), 32'd0);
        chk("t3_miss_data", fwd_data,     32'd0);
        mem_ready = 1'b1;
        repeat (3) step();

        // 4: full + push attempt + pop, then push and pop together, wrap order
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'h40 + 32'(i * 4), 32'h10 + 32'(i), 32'h6000 + 32'(i * 4));
        mem_ready = 1'b1;
        push_one(32'h50, 32'h14, 32'h6010);
        chk("t4_pop_only_ready", 32'(st_ready), 32'd1);
        chk("t4_pop_only_head",  mem_addr,      32'h44);
        chk("t4_pop_only_data",  mem_wdata,     32'h11);
        push_one(32'h54, 32'h15, 32'h6014);
        chk("t4_both_ready", 32'(st_ready), 32'd1);
        chk("t4_both_head",  mem_addr,      32'h48);
        chk("t4_order_0",    mem_wdata,     32'h12);
        step();
        chk("t4_order_1",    mem_wdata,     32'h13);
        step();
        chk("t4_order_2",    mem_wdata,     32'h15);
        chk("t4_order_2a",   mem_addr,      32'h54);
        step();
        chk("t4_empty", 32'(empty), 32'd1);

        // 5: reset discards pending entries and overrides push/pop
        mem_ready = 1'b0;
        push_one(32'h60, 32'h21, 32'h7000);
        push_one(32'h64, 32'h22, 32'h7004);
        push_one(32'h68, 32'h23, 32'h7008);
        reset     = 1'b1;
        mem_ready = 1'b1;
        push_one(32'h6C, 32'h24, 32'h700C);
        reset = 1'b0;
        chk("t5_empty",    32'(empty),    32'd1);
        chk("t5_mem_we",   32'(mem_we),   32'd0);
        chk("t5_st_ready", 32'(st_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_present", 32'(mem_we), 32'd0);
        end

        // 6: random traffic against the model
        for (int c = 0; c < 10000; c++) begin
            reset     = ($urandom_range(0, 999) == 0);
            st_valid  = ($urandom_range(0, 1) == 1) && (q.size() < DEPTH);
            st_addr   = 32'h100 | ($urandom() & 32'h1F);
            st_wdata  = $urandom();
            st_pc     = $urandom();
            ld_addr   = 32'h100 | ($urandom() & 32'h1F);
            mem_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        reset    = 1'b0;
        st_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
